// File: rtl/tl_buffer_pkg.sv
// tl_buffer_pkg: default TileLink-UL widths, channel payload structs and
// sizing helpers shared by the buffer, its queues and the link interface.
package tl_buffer_pkg;

  localparam int TL_ADDR_W   = 31;
  localparam int TL_DATA_W   = 64;
  localparam int TL_SOURCE_W = 3;
  localparam int TL_SIZE_W   = 4;
  localparam int TL_SINK_W   = 1;

  typedef struct packed {
    logic [2:0]               opcode;
    logic [2:0]               param;
    logic [TL_SIZE_W-1:0]     size;
    logic [TL_SOURCE_W-1:0]   source;
    logic [TL_ADDR_W-1:0]     address;
    logic [TL_DATA_W/8-1:0]   mask;
    logic [TL_DATA_W-1:0]     data;
    logic                     corrupt;
  } tl_a_t;

  typedef struct packed {
    logic [2:0]               opcode;
    logic [1:0]               param;
    logic [TL_SIZE_W-1:0]     size;
    logic [TL_SOURCE_W-1:0]   source;
    logic [TL_SINK_W-1:0]     sink;
    logic                     denied;
    logic [TL_DATA_W-1:0]     data;
    logic                     corrupt;
  } tl_d_t;

  // Occupancy counter width; a wire-only channel still gets one (tied-off) bit.
  function automatic int count_w(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

  // Flattened A payload width for arbitrary field widths.
  function automatic int a_width(input int size_w, input int source_w,
                                 input int addr_w, input int data_w);
    return 3 + 3 + size_w + source_w + addr_w + data_w / 8 + data_w + 1;
  endfunction

  // Flattened D payload width for arbitrary field widths.
  function automatic int d_width(input int size_w, input int source_w,
                                 input int sink_w, input int data_w);
    return 3 + 2 + size_w + source_w + sink_w + 1 + data_w + 1;
  endfunction

endpackage

// File: rtl/tl_buffer_param_if.sv
// tl_buffer_param_if: one TileLink-UL link (A and D channels). The client
// side uses the master modport, the manager side the slave modport.
interface tl_buffer_param_if import tl_buffer_pkg::*; #(
  parameter int ADDR_W   = TL_ADDR_W,
  parameter int DATA_W   = TL_DATA_W,
  parameter int SOURCE_W = TL_SOURCE_W,
  parameter int SIZE_W   = TL_SIZE_W,
  parameter int SINK_W   = TL_SINK_W
) ();

  logic                a_ready;
  logic                a_valid;
  logic [2:0]          a_bits_opcode;
  logic [2:0]          a_bits_param;
  logic [SIZE_W-1:0]   a_bits_size;
  logic [SOURCE_W-1:0] a_bits_source;
  logic [ADDR_W-1:0]   a_bits_address;
  logic [DATA_W/8-1:0] a_bits_mask;
  logic [DATA_W-1:0]   a_bits_data;
  logic                a_bits_corrupt;

  logic                d_ready;
  logic                d_valid;
  logic [2:0]          d_bits_opcode;
  logic [1:0]          d_bits_param;
  logic [SIZE_W-1:0]   d_bits_size;
  logic [SOURCE_W-1:0] d_bits_source;
  logic [SINK_W-1:0]   d_bits_sink;
  logic                d_bits_denied;
  logic [DATA_W-1:0]   d_bits_data;
  logic                d_bits_corrupt;

  modport master (
    input  a_ready,
    output a_valid, a_bits_opcode, a_bits_param, a_bits_size, a_bits_source,
           a_bits_address, a_bits_mask, a_bits_data, a_bits_corrupt,
    output d_ready,
    input  d_valid, d_bits_opcode, d_bits_param, d_bits_size, d_bits_source,
           d_bits_sink, d_bits_denied, d_bits_data, d_bits_corrupt
  );

  modport slave (
    output a_ready,
    input  a_valid, a_bits_opcode, a_bits_param, a_bits_size, a_bits_source,
           a_bits_address, a_bits_mask, a_bits_data, a_bits_corrupt,
    input  d_ready,
    output d_valid, d_bits_opcode, d_bits_param, d_bits_size, d_bits_source,
           d_bits_sink, d_bits_denied, d_bits_data, d_bits_corrupt
  );

endinterface

// File: rtl/tl_buffer_queue.sv
// tl_buffer_queue: ready/valid circular queue of DEPTH entries (any DEPTH,
// not only powers of two); DEPTH 0 collapses to plain wires.
// Build option TL_BUFFER_FLOW_EN: an empty queue forwards the incoming beat
// combinationally, and stores it only if the consumer is not ready.
module tl_buffer_queue import tl_buffer_pkg::*; #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 8,
  localparam int CW    = count_w(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [WIDTH-1:0] enq_bits,
  output logic             deq_valid,
  input  logic             deq_ready,
  output logic [WIDTH-1:0] deq_bits,
  output logic [CW-1:0]    count
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = clock ^ reset;
      assign deq_valid      = enq_valid;
      assign deq_bits       = enq_bits;
      assign enq_ready      = deq_ready;
      assign count          = '0;
    end else begin : g_queue
      localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

      logic [WIDTH-1:0] storage [DEPTH];
      logic [PW-1:0]    enq_ptr;
      logic [PW-1:0]    deq_ptr;
      logic [CW-1:0]    cnt;
      logic             empty;
      logic             full;
      logic             do_enq;
      logic             do_deq;

      // Pointers wrap by explicit compare so odd depths work.
      function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
      endfunction

      assign empty     = (cnt == '0);
      assign full      = (cnt == CW'(DEPTH));
      assign enq_ready = !full;
      assign count     = cnt;

`ifdef TL_BUFFER_FLOW_EN
      assign deq_valid = !empty || enq_valid;
      assign deq_bits  = empty ? enq_bits : storage[deq_ptr];
      assign do_enq    = enq_valid && !full && !(empty && deq_ready);
      assign do_deq    = deq_ready && !empty;
`else
      assign deq_valid = !empty;
      assign deq_bits  = storage[deq_ptr];
      assign do_enq    = enq_valid && !full;
      assign do_deq    = deq_ready && !empty;
`endif

      // Pointer and occupancy bookkeeping; enq+deq together leaves cnt alone.
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          enq_ptr <= '0;
          deq_ptr <= '0;
          cnt     <= '0;
        end else begin
          if (do_enq) enq_ptr <= next_ptr(enq_ptr);
          if (do_deq) deq_ptr <= next_ptr(deq_ptr);
          if (do_enq && !do_deq)      cnt <= cnt + CW'(1);
          else if (!do_enq && do_deq) cnt <= cnt - CW'(1);
        end
      end

      // Payload storage, cleared on reset so idle outputs read zero.
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < DEPTH; i++) storage[i] <= '0;
        end else if (do_enq) begin
          storage[enq_ptr] <= enq_bits;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/tl_buffer_param.sv
// tl_buffer_param: TileLink-UL buffer with independently sized A and D
// queues; depth 0 on a channel is a straight wire.
// Build option TL_BUFFER_FLOW_EN enables empty-queue flow-through.
module tl_buffer_param import tl_buffer_pkg::*; #(
  parameter int A_DEPTH  = 2,
  parameter int D_DEPTH  = 2,
  parameter int ADDR_W   = TL_ADDR_W,
  parameter int DATA_W   = TL_DATA_W,
  parameter int SOURCE_W = TL_SOURCE_W,
  parameter int SIZE_W   = TL_SIZE_W,
  parameter int SINK_W   = TL_SINK_W
) (
  input  logic                         clock,
  input  logic                         reset,
  tl_buffer_param_if.slave             auto_in,
  tl_buffer_param_if.master            auto_out,
  output logic [count_w(A_DEPTH)-1:0]  a_count,
  output logic [count_w(D_DEPTH)-1:0]  d_count
);

  localparam int AW = a_width(SIZE_W, SOURCE_W, ADDR_W, DATA_W);
  localparam int DW = d_width(SIZE_W, SOURCE_W, SINK_W, DATA_W);

  logic [AW-1:0] a_enq_bits;
  logic [AW-1:0] a_deq_bits;
  logic [DW-1:0] d_enq_bits;
  logic [DW-1:0] d_deq_bits;

  assign a_enq_bits = {auto_in.a_bits_opcode, auto_in.a_bits_param,
                       auto_in.a_bits_size, auto_in.a_bits_source,
                       auto_in.a_bits_address, auto_in.a_bits_mask,
                       auto_in.a_bits_data, auto_in.a_bits_corrupt};

  assign {auto_out.a_bits_opcode, auto_out.a_bits_param,
          auto_out.a_bits_size, auto_out.a_bits_source,
          auto_out.a_bits_address, auto_out.a_bits_mask,
          auto_out.a_bits_data, auto_out.a_bits_corrupt} = a_deq_bits;

  assign d_enq_bits = {auto_out.d_bits_opcode, auto_out.d_bits_param,
                       auto_out.d_bits_size, auto_out.d_bits_source,
                       auto_out.d_bits_sink, auto_out.d_bits_denied,
                       auto_out.d_bits_data, auto_out.d_bits_corrupt};

  assign {auto_in.d_bits_opcode, auto_in.d_bits_param,
          auto_in.d_bits_size, auto_in.d_bits_source,
          auto_in.d_bits_sink, auto_in.d_bits_denied,
          auto_in.d_bits_data, auto_in.d_bits_corrupt} = d_deq_bits;

  tl_buffer_queue #(.DEPTH(A_DEPTH), .WIDTH(AW)) u_a_queue (
    .clock     (clock),
    .reset     (reset),
    .enq_valid (auto_in.a_valid),
    .enq_ready (auto_in.a_ready),
    .enq_bits  (a_enq_bits),
    .deq_valid (auto_out.a_valid),
    .deq_ready (auto_out.a_ready),
    .deq_bits  (a_deq_bits),
    .count     (a_count)
  );

  tl_buffer_queue #(.DEPTH(D_DEPTH), .WIDTH(DW)) u_d_queue (
    .clock     (clock),
    .reset     (reset),
    .enq_valid (auto_out.d_valid),
    .enq_ready (auto_out.d_ready),
    .enq_bits  (d_enq_bits),
    .deq_valid (auto_in.d_valid),
    .deq_ready (auto_in.d_ready),
    .deq_bits  (d_deq_bits),
    .count     (d_count)
  );

endmodule
